// File: rtl/debounce_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding and
// default parameter values.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_WAIT_HIGH = 2'd1,
    ST_HIGH      = 2'd2,
    ST_WAIT_LOW  = 2'd3
  } state_e;

  localparam int unsigned DEF_SYNC_STAGES     = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
  localparam int unsigned DEF_HOLD_CYCLES     = 1000;

endpackage

// File: rtl/sync_ff_chain.sv
// Generic flop-chain synchroniser with asynchronous active-low reset.
// Brings a single asynchronous bit into the clk domain; q_o is the last stage.
module sync_ff_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// Push-button conditioner: synchronises the raw pad, rejects contact bounce
// with a stability counter, and produces a clean level plus press/release
// pulses. Optional long-press detection is enabled by defining the macro
// BUTTON_DEBOUNCE_LONG_PRESS_EN; otherwise long_press is tied low.
//
// state        | meaning
// -------------+-------------------------------------------------------
// ST_LOW       | clean level 0, waiting for a 1 sample
// ST_WAIT_HIGH | qualifying a 0->1 change, cnt counts stable 1 samples
// ST_HIGH      | clean level 1, waiting for a 0 sample
// ST_WAIT_LOW  | qualifying a 1->0 change, cnt counts stable 0 samples
module button_debounce
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_clean,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Catch illegal parameterisations at elaboration time.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("button_debounce: SYNC_STAGES must be 2..4");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce_cycles
    $error("button_debounce: DEBOUNCE_CYCLES must be >= 2");
  end
  if (HOLD_CYCLES < 2) begin : g_bad_hold_cycles
    $error("button_debounce: HOLD_CYCLES must be >= 2");
  end

  logic             sync_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clean_q, clean_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  sync_ff_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (btn_raw),
    .q_o   (sync_q)
  );

  // FSM state, stability counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_LOW;
      cnt_q     <= '0;
      clean_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clean_q   <= clean_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Next-state logic: any opposite sample during qualification restarts from LOW/HIGH.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clean_d   = clean_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      ST_LOW: begin
        if (sync_q) begin
          state_d = ST_WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      ST_WAIT_HIGH: begin
        if (!sync_q) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
          clean_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HIGH: begin
        if (!sync_q) begin
          state_d = ST_WAIT_LOW;
          cnt_d   = '0;
        end
      end
      ST_WAIT_LOW: begin
        if (sync_q) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_LOW;
          cnt_d     = '0;
          clean_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  assign btn_clean     = clean_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              hold_done_q, hold_done_d;
  logic              long_q, long_d;

  // Hold timer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q  <= '0;
      hold_done_q <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      hold_cnt_q  <= hold_cnt_d;
      hold_done_q <= hold_done_d;
      long_q      <= long_d;
    end
  end

  // Hold timer restarts on each accepted press and fires once; a short
  // glitch back to HIGH continues the same hold rather than restarting it.
  always_comb begin
    hold_cnt_d  = hold_cnt_q;
    hold_done_d = hold_done_q;
    long_d      = 1'b0;
    if (press_d) begin
      hold_cnt_d  = '0;
      hold_done_d = 1'b0;
    end else if ((state_q == ST_HIGH || state_q == ST_WAIT_LOW) && !hold_done_q) begin
      if (hold_cnt_q == HOLD_LAST && clean_q) begin
        long_d      = 1'b1;
        hold_done_d = 1'b1;
      end else if (hold_cnt_q != HOLD_LAST) begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end
    end
  end

  assign long_press = long_q;
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce (SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
// HOLD_CYCLES=20). Long-press expectations follow BUTTON_DEBOUNCE_LONG_PRESS_EN.
module tb_button_debounce;

  localparam int unsigned SYNC = 2;
  localparam int unsigned DEB  = 4;
  localparam int unsigned HOLD = 20;
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic btn_raw;
  logic btn_clean, press_pulse, release_pulse, long_press;

  int tests = 0;
  int failed = 0;
  int press_cnt = 0, rel_cnt = 0, long_cnt = 0, both_cnt = 0;
  int pbase, rbase, lbase;

  button_debounce #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB),
    .HOLD_CYCLES     (HOLD)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_raw       (btn_raw),
    .btn_clean     (btn_clean),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_press    (long_press)
  );

  always #5 clk = ~clk;

  // Pulse tallies, sampled mid-cycle.
  always @(negedge clk) begin
    if (press_pulse)                  press_cnt <= press_cnt + 1;
    if (release_pulse)                rel_cnt   <= rel_cnt + 1;
    if (long_press)                   long_cnt  <= long_cnt + 1;
    if (press_pulse && release_pulse) both_cnt  <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    btn_raw = 1'b0;
    #12;
    chk("rst_clean", btn_clean, 0);
    chk("rst_press", press_pulse, 0);
    chk("rst_release", release_pulse, 0);
    chk("rst_long", long_press, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: idle low after reset
    tick(20);
    chk("idle_clean", btn_clean, 0);
    chk("idle_press", press_pulse, 0);
    chk("idle_release", release_pulse, 0);
    chk("idle_long", long_press, 0);
    chk("idle_press_cnt", press_cnt, 0);
    chk("idle_rel_cnt", rel_cnt, 0);

    // 2: clean press, pulse at edge 7
    btn_raw = 1'b1;
    tick(6);
    chk("p2_e6_clean", btn_clean, 0);
    chk("p2_e6_press", press_pulse, 0);
    tick(1);
    chk("p2_e7_press", press_pulse, 1);
    chk("p2_e7_clean", btn_clean, 1);
    tick(1);
    chk("p2_e8_press", press_pulse, 0);
    chk("p2_e8_clean", btn_clean, 1);
    chk("p2_press_cnt", press_cnt, 1);

    // symmetric release
    btn_raw = 1'b0;
    tick(6);
    chk("r2_e6_clean", btn_clean, 1);
    chk("r2_e6_release", release_pulse, 0);
    tick(1);
    chk("r2_e7_release", release_pulse, 1);
    chk("r2_e7_clean", btn_clean, 0);
    chk("r2_e7_press", press_pulse, 0);
    tick(1);
    chk("r2_e8_release", release_pulse, 0);
    chk("r2_rel_cnt", rel_cnt, 1);
    tick(3);

    // 3: bounce 1,0,1,0 on 2-cycle spacing, then stable 1
    pbase = press_cnt;
    for (int i = 0; i < 4; i++) begin
      btn_raw = (i % 2 == 0);
      for (int j = 0; j < 2; j++) begin
        tick(1);
        chk("b3_bounce_clean", btn_clean, 0);
      end
    end
    btn_raw = 1'b1;
    tick(6);
    chk("b3_e6_clean", btn_clean, 0);
    chk("b3_e6_press", press_pulse, 0);
    tick(1);
    chk("b3_e7_press", press_pulse, 1);
    chk("b3_e7_clean", btn_clean, 1);
    tick(1);
    chk("b3_one_press", press_cnt - pbase, 1);

    // 4: 3-cycle low glitch while clean high
    rbase = rel_cnt;
    btn_raw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("g4_low_clean", btn_clean, 1);
    end
    btn_raw = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("g4_recover_clean", btn_clean, 1);
    end
    chk("g4_no_release", rel_cnt - rbase, 0);

    // release completing before the hold timeout: no long_press
    btn_raw = 1'b0;
    tick(7);
    chk("r4_release", release_pulse, 1);
    chk("r4_clean", btn_clean, 0);
    chk("r4_no_long", long_cnt, 0);
    tick(3);

    // 5: reset during WAIT_HIGH (cnt=2), then re-qualify from scratch
    btn_raw = 1'b1;
    tick(5);
    #2 rst_n = 1'b0;
    #1;
    chk("r5_clean", btn_clean, 0);
    chk("r5_press", press_pulse, 0);
    chk("r5_release", release_pulse, 0);
    chk("r5_long", long_press, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    pbase = press_cnt;
    tick(6);
    chk("r5_e6_clean", btn_clean, 0);
    chk("r5_e6_press", press_pulse, 0);
    tick(1);
    chk("r5_e7_press", press_pulse, 1);
    chk("r5_e7_clean", btn_clean, 1);

    // reset while clean high clears the level asynchronously
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    chk("r5b_async_clean", btn_clean, 0);
    chk("r5b_no_pulse_cnt", press_cnt - pbase, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 6: long hold
    pbase = press_cnt;
    lbase = long_cnt;
    tick(7);
    chk("h6_press", press_pulse, 1);
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      chk("h6_long", long_press, (LONG_EN && k == HOLD) ? 1 : 0);
    end
    chk("h6_long_cnt", long_cnt - lbase, LONG_EN ? 1 : 0);
    chk("h6_single_press", press_cnt - pbase, 1);
    chk("h6_clean", btn_clean, 1);

    btn_raw = 1'b0;
    tick(7);
    chk("h6_release", release_pulse, 1);
    tick(5);
    chk("h6_final_clean", btn_clean, 0);
    chk("no_overlap", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
